buffer_read_sequencer: RTL and testbench
========================================

# buffer_read_sequencer

Drains the matrix input buffer in write order, one word per cycle, to the downstream multiplier datapath over a valid/ready stream. It sits directly downstream of the buffer write address generator: it compares that block's free-running 16-bit write count against its own read count, issues synchronous-RAM reads, and absorbs the 1-cycle RAM latency in a 2-entry output FIFO. It flags a sticky overflow when the writer laps the reader.

## Interface
- BUFFER_ADDRESS_WIDTH, 10, buffer address width; buffer depth is 2^BUFFER_ADDRESS_WIDTH words.
- DATA_WIDTH, 32, buffer word width.

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; clears read count, FIFO and overflow, enters RUN (same pulse the writer uses).
- write_count_i  in  16  writer's global count, registered in the writer.
- rd_en_o  out  1  buffer read enable.
- rd_addr_o  out  BUFFER_ADDRESS_WIDTH  buffer read address = read_count_o[BUFFER_ADDRESS_WIDTH-1:0].
- rd_data_i  in  DATA_WIDTH  buffer read data, valid the cycle after rd_en_o.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_WIDTH  FIFO head data.
- read_count_o  out  16  words issued for read since start_i.
- empty_o  out  1  high when available == 0.
- overflow_o  out  1  sticky writer-lapped-reader error.

## Operation
- States: IDLE (after reset), RUN, HALT. IDLE->RUN on start_i. RUN->HALT when overflow is detected. Any state->RUN on start_i. Reads are issued only in RUN.
- available = write_count_i - read_count_o, modulo 2^16, unsigned.
- Overflow is detected in RUN when available > 2^BUFFER_ADDRESS_WIDTH. It sets overflow_o and moves to HALT. overflow_o is cleared only by start_i or reset.
- pop = out_valid_o && out_ready_i.
- Issue condition: RUN && available != 0 && (fifo_count + inflight - pop) < 2.
- rd_en_o is asserted combinationally from the issue condition. Each issue increments read_count_o by 1; it wraps modulo 2^16.
- inflight is a 1-bit register set by an issue. Next cycle, rd_data_i is pushed into the FIFO if inflight is set and no start_i occurred in between.
- FIFO: 2 entries, in order. Push and pop in the same cycle are allowed. out_data_o is the head entry.
- start_i, in any state and in any combination with other events:
  - read_count_o <= 0, fifo_count <= 0, inflight <= 0, overflow_o <= 0, state <= RUN.
  - No issue occurs in the start_i cycle.
  - Data returning from a read issued the cycle before start_i is discarded.
- In HALT, the FIFO still drains on out_ready_i, but no new reads are issued. A return from a read already in flight is still pushed.

## Timing
- Reset values: state IDLE, read_count_o 0, rd_en_o 0, out_valid_o 0, out_data_o 0, empty_o 1 (with write_count_i 0), overflow_o 0.
- Latency: rd_en_o in cycle t -> data captured into the FIFO at the end of t+1 -> out_valid_o high in t+2.
- Throughput: 1 word/cycle sustained while out_ready_i is held high and available > 0.
- Backpressure: with out_ready_i low, at most 2 words are buffered (FIFO full, inflight 0). out_data_o and out_valid_o stay stable while out_valid_o && !out_ready_i.
- Wrap-around:
  - rd_addr_o wraps at 2^BUFFER_ADDRESS_WIDTH.
  - read_count_o wraps at 2^16.
  - available stays correct across the 16-bit wrap because the subtraction is modular.
- available == 2^BUFFER_ADDRESS_WIDTH exactly is legal (buffer full); it is not an overflow.

## Test plan
- Reset, start_i, then the writer increments write_count_i 0->4 over 4 cycles, out_ready_i=1 -> rd_addr_o 0,1,2,3 on consecutive cycles, each starting one cycle after the matching write count. out_data_o carries words 0..3, each 2 cycles after its rd_en_o. Afterwards empty_o=1 and read_count_o=4.
- write_count_i=8, out_ready_i=0 for 10 cycles -> exactly 2 issues, then rd_en_o=0 and out_valid_o stays high on word 0. Release out_ready_i -> words 0..7 arrive in order with no gaps or duplicates.
- write_count_i jumps from 0 to 2^BUFFER_ADDRESS_WIDTH+1 (1025) -> overflow_o=1 the next cycle, state HALT, no further rd_en_o. start_i -> overflow_o=0, read_count_o=0.
- read_count_o=0xFFFE, write_count_i steps to 0x0002 -> 4 reads issued at addresses 0x3FE, 0x3FF, 0x000, 0x001. overflow_o stays 0.
- start_i asserted in the cycle right after an rd_en_o, with the FIFO holding 1 word -> the returned word is discarded, out_valid_o=0 the next cycle, read_count_o=0.
- Assert reset_n low mid-stream with the FIFO full -> all outputs take their reset values immediately (asynchronously), and the state is IDLE.

Source files
------------

// File: rtl/buffer_read_sequencer.sv
// rtl/buffer_read_sequencer.sv - drains the matrix input buffer in write order into a 2-entry output FIFO
// Compares the writer's free-running count to the read count and hides the 1-cycle RAM latency.
module buffer_read_sequencer #(
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH           = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  input  logic [15:0]                     write_count_i,
  output logic                            rd_en_o,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0]           rd_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [15:0]                     read_count_o,
  output logic                            empty_o,
  output logic                            overflow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << BUFFER_ADDRESS_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           read_count_q, read_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_count_q, fifo_count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  overflow_q, overflow_d;

  logic [15:0] available;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;
  logic        issue;

  // Modular subtraction keeps the fill level correct across the 16-bit wrap.
  assign available = write_count_i - read_count_q;
  assign pop       = (fifo_count_q != 2'd0) && out_ready_i;
  assign push      = inflight_q;
  assign occupancy = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = !start_i && (state_q == RUN) && (available != 16'd0) && (occupancy < 3'd2);

  always_comb begin
    state_d      = state_q;
    read_count_d = read_count_q;
    inflight_d   = inflight_q;
    fifo_count_d = fifo_count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    overflow_d   = overflow_q;

    if (start_i) begin
      // A return from a read issued just before start is dropped by clearing inflight.
      state_d      = RUN;
      read_count_d = 16'd0;
      inflight_d   = 1'b0;
      fifo_count_d = 2'd0;
      overflow_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        read_count_d = read_count_q + 16'd1;
      end
      if ((state_q == RUN) && ({1'b0, available} > DEPTH)) begin
        overflow_d = 1'b1;
        state_d    = HALT;
      end

      case ({push, pop})
        2'b10: begin
          if (fifo_count_q == 2'd0) begin
            head_d = rd_data_i;
          end else begin
            tail_d = rd_data_i;
          end
          fifo_count_d = fifo_count_q + 2'd1;
        end
        2'b01: begin
          head_d       = tail_q;
          fifo_count_d = fifo_count_q - 2'd1;
        end
        2'b11: begin
          if (fifo_count_q == 2'd1) begin
            head_d = rd_data_i;
          end else begin
            head_d = tail_q;
            tail_d = rd_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      read_count_q <= 16'd0;
      inflight_q   <= 1'b0;
      fifo_count_q <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_count_q <= read_count_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rd_en_o      = issue;
  assign rd_addr_o    = read_count_q[BUFFER_ADDRESS_WIDTH-1:0];
  assign out_valid_o  = (fifo_count_q != 2'd0);
  assign out_data_o   = head_q;
  assign read_count_o = read_count_q;
  assign empty_o      = (available == 16'd0);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_buffer_read_sequencer.sv
// tb/tb_buffer_read_sequencer.sv - randomized and directed bench for buffer_read_sequencer
// A queue-based reference model is compared against the DUT every cycle.
module tb_buffer_read_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic [15:0]   write_count_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [15:0]   read_count_o;
  logic          empty_o;
  logic          overflow_o;

  buffer_read_sequencer #(.BUFFER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .write_count_i(write_count_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .read_count_o(read_count_o), .empty_o(empty_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] addr);
    return (32'(addr) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous RAM stub: one cycle read latency.
  always @(posedge clk) begin
    if (rd_en_o === 1'b1) rd_data_i <= ram_word(rd_addr_o);
  end

  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 run, 2 halt.
  int            m_state;
  int            m_rc;
  bit            m_inflight;
  logic [AW-1:0] m_infl_addr;
  logic [DW-1:0] m_q[$];
  bit            m_ovf;
  bit            m_issue, m_pop;
  int            m_avail;
  int            dut_issues;
  logic [AW-1:0] addr_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rc = 0; m_inflight = 0; m_q.delete(); m_ovf = 0;
  endtask

  task automatic compare();
    m_avail = (int'(write_count_i) - m_rc) & 16'hFFFF;
    m_pop   = (m_q.size() > 0) && out_ready_i;
    m_issue = reset_n && !start_i && m_state == 1 && m_avail != 0 &&
              (m_q.size() + int'(m_inflight) - int'(m_pop)) < 2;
    if (rd_en_o === 1'b1) begin
      dut_issues++;
      addr_log.push_back(rd_addr_o);
    end
    check("rd_en", 64'(rd_en_o), 64'(m_issue));
    if (m_issue) check("rd_addr", 64'(rd_addr_o), 64'(m_rc & 16'h3FF));
    check("out_valid", 64'(out_valid_o), 64'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", 64'(out_data_o), 64'(m_q[0]));
    check("read_count", 64'(read_count_o), 64'(m_rc));
    check("empty", 64'(empty_o), 64'(m_avail == 0));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_reset();
    end else if (start_i) begin
      m_state = 1; m_rc = 0; m_inflight = 0; m_q.delete(); m_ovf = 0;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(ram_word(m_infl_addr));
      m_inflight  = m_issue;
      m_infl_addr = AW'(m_rc);
      if (m_issue) m_rc = (m_rc + 1) & 16'hFFFF;
      if (m_state == 1 && m_avail > (1 << AW)) begin
        m_ovf = 1; m_state = 2;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; write_count_i = 16'd0;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; write_count_i = 16'd0; out_ready_i = 1'b0;
    model_reset();
    #1;
    check("reset_out_data", 64'(out_data_o), 64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Writer increments 0->4, downstream always ready.
    pulse_start();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      write_count_i = 16'(i);
      step();
    end
    repeat (4) step();
    check("t1_read_count", 64'(read_count_o), 64'd4);
    check("t1_empty", 64'(empty_o), 64'd1);

    // Backpressure: only two words may be fetched.
    pulse_start();
    write_count_i = 16'd8; out_ready_i = 1'b0; dut_issues = 0;
    repeat (10) step();
    check("bp_issue_count", 64'(dut_issues), 64'd2);
    check("bp_head", 64'(out_data_o), 64'(ram_word(AW'(0))));
    out_ready_i = 1'b1;
    repeat (12) step();

    // Randomized traffic with occasional restarts.
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      out_ready_i = ($urandom % 4) != 0;
      if ((((int'(write_count_i) - m_rc) & 16'hFFFF) < 1000))
        write_count_i = write_count_i + 16'($urandom_range(0, 2));
      if (($urandom % 64) == 0) pulse_start();
      else step();
    end

    // Writer laps the reader.
    pulse_start();
    write_count_i = 16'd1025; out_ready_i = 1'b1;
    step();
    check("ovf_set", 64'(overflow_o), 64'd1);
    dut_issues = 0;
    repeat (4) step();
    check("ovf_no_issue", 64'(dut_issues), 64'd0);
    pulse_start();
    check("ovf_cleared", 64'(overflow_o), 64'd0);
    check("ovf_rc_zero", 64'(read_count_o), 64'd0);

    // Walk the read count up to 0xFFFE, then cross the 16-bit wrap.
    out_ready_i = 1'b1;
    while (m_rc < 16'hFFFE) begin
      write_count_i = (m_rc + 1024 > 16'hFFFE) ? 16'hFFFE : 16'(m_rc + 1024);
      step();
    end
    repeat (3) step();
    check("wrap_start_rc", 64'(read_count_o), 64'hFFFE);
    addr_log.delete();
    for (int i = 0; i < 4; i++) begin
      write_count_i = write_count_i + 16'd1;
      step();
    end
    repeat (3) step();
    check("wrap_n", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", 64'(addr_log[0]), 64'h3FE);
      check("wrap_a1", 64'(addr_log[1]), 64'h3FF);
      check("wrap_a2", 64'(addr_log[2]), 64'h000);
      check("wrap_a3", 64'(addr_log[3]), 64'h001);
    end
    check("wrap_ovf", 64'(overflow_o), 64'd0);

    // Restart right after an issue while the FIFO holds one word.
    pulse_start();
    out_ready_i = 1'b0; write_count_i = 16'd1;
    step();
    step();
    write_count_i = 16'd2;
    dut_issues = 0;
    step();
    check("rs_issue", 64'(dut_issues), 64'd1);
    start_i = 1'b1; write_count_i = 16'd0;
    step();
    start_i = 1'b0;
    #4;
    check("rs_valid", 64'(out_valid_o), 64'd0);
    check("rs_rc", 64'(read_count_o), 64'd0);
    step();

    // Asynchronous reset with the FIFO full.
    pulse_start();
    write_count_i = 16'd5; out_ready_i = 1'b0;
    repeat (5) step();
    check("ar_full", 64'(out_valid_o), 64'd1);
    reset_n = 1'b0; write_count_i = 16'd0;
    model_reset();
    #1;
    compare();
    check("ar_out_data", 64'(out_data_o), 64'd0);
    repeat (2) step();
    reset_n = 1'b1; write_count_i = 16'd3;
    dut_issues = 0;
    repeat (3) step();
    check("ar_idle_no_issue", 64'(dut_issues), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
